// File: rtl/serial_divisibility_scheduler.sv
// serial_divisibility_scheduler
//   One serial residue engine shared by two requesters. A granted W-bit word is
//   shifted in MSB-first through r = (2r + bit) mod divisor, one bit per clock,
//   and the final remainder plus a divisible flag are offered on a result port.
//   Optional build macro: SERIAL_DIV_ABORT_EN adds an abort input that cancels
//   the job in flight without delivering a result.
//
// Handshakes: a word moves on any rising edge where reqN_valid && reqN_ready.
//   reqN_ready is combinational, only ever high in IDLE, and high for at most
//   one requester. A result moves on any rising edge where res_valid &&
//   res_ready. res_valid/res_src/res_div/res_rem stay stable until then.
module serial_divisibility_scheduler #(
  parameter int W  = 16,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] divisor,
  input  logic          req0_valid,
  input  logic [W-1:0]  req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [W-1:0]  req1_data,
  output logic          req1_ready,
  output logic          res_valid,
  input  logic          res_ready,
`ifdef SERIAL_DIV_ABORT_EN
  input  logic          abort,
`endif
  output logic          res_src,
  output logic          res_div,
  output logic [DW-1:0] res_rem,
  output logic          busy
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // state is kept as a named enum so checkers can bind to it directly
  state_t        state;
  state_t        state_next;

  logic [W-1:0]  data_q;
  logic [DW-1:0] div_q;
  logic [DW-1:0] rem_q;
  logic [CW-1:0] cnt_q;
  logic          src_q;
  logic          rr_q;     // requester that wins when both are valid

  logic          grant0;
  logic          grant1;
  logic          accept;

  logic [DW:0]   t_sum;
  logic [DW:0]   t_diff;
  logic [DW-1:0] rem_step;

  // next-state and grant decision; grants only happen in IDLE
  always_comb begin
    state_next = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid && (!req1_valid || !rr_q)) begin
          grant0 = 1'b1;
        end else if (req1_valid) begin
          grant1 = 1'b1;
        end
        if (grant0 || grant1) begin
          // a zero divisor has nothing to shift: straight to the error result
          state_next = (divisor == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == CW'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
`ifdef SERIAL_DIV_ABORT_EN
    // abort wins over a result handshake in the same cycle
    if (abort && (state != IDLE)) begin
      state_next = IDLE;
      grant0     = 1'b0;
      grant1     = 1'b0;
    end
`endif
  end

  assign accept = grant0 | grant1;

  // one residue step: the remainder stays below the divisor, so t < 2*div
  // and a single conditional subtract is enough
  always_comb begin
    t_sum    = {rem_q, data_q[W-1]};
    t_diff   = t_sum - {1'b0, div_q};
    rem_step = (t_sum >= {1'b0, div_q}) ? t_diff[DW-1:0] : t_sum[DW-1:0];
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // job datapath: latch on accept, step the residue while shifting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      div_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      src_q  <= 1'b0;
      rr_q   <= 1'b0;
    end else if (accept) begin
      data_q <= grant1 ? req1_data : req0_data;
      div_q  <= divisor;
      rem_q  <= '0;
      cnt_q  <= CW'(W);
      src_q  <= grant1;
      rr_q   <= grant0;  // pointer moves to the requester that did not win
    end else if (state == SHIFT) begin
      rem_q  <= rem_step;
      data_q <= {data_q[W-2:0], 1'b0};
      cnt_q  <= cnt_q - CW'(1);
    end
  end

  // result outputs are only driven while a result is on offer, so they fall
  // to zero the moment reset asserts
  always_comb begin
    req0_ready = grant0;
    req1_ready = grant1;
    res_valid  = (state == DONE);
    res_src    = (state == DONE) ? src_q : 1'b0;
    res_rem    = (state == DONE) ? rem_q : '0;
    res_div    = (state == DONE) && (div_q != '0) && (rem_q == '0);
    busy       = (state != IDLE);
  end

endmodule

// File: tb/tb_serial_divisibility_scheduler.sv
// Bench for serial_divisibility_scheduler (W=16, DW=4). A per-cycle sampler
// predicts grants, result timing and result contents from plain arithmetic
// (operand % divisor) and a round-robin rule, with an expected queue.
module tb_serial_divisibility_scheduler;
  localparam int W  = 16;
  localparam int DW = 4;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] divisor    = '0;
  logic          req0_valid = 1'b0;
  logic [W-1:0]  req0_data  = '0;
  logic          req0_ready;
  logic          req1_valid = 1'b0;
  logic [W-1:0]  req1_data  = '0;
  logic          req1_ready;
  logic          res_valid;
  logic          res_ready  = 1'b0;
  logic          res_src;
  logic          res_div;
  logic [DW-1:0] res_rem;
  logic          busy;
  logic          abort_s;

`ifdef SERIAL_DIV_ABORT_EN
  logic abort = 1'b0;
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  serial_divisibility_scheduler #(.W(W), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .divisor    (divisor),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
`ifdef SERIAL_DIV_ABORT_EN
    .abort      (abort),
`endif
    .res_src    (res_src),
    .res_div    (res_div),
    .res_rem    (res_rem),
    .busy       (busy)
  );

  // scoreboard state
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [DW+1:0] exp_q[$];     // {src, div, rem}
  logic [DW+1:0] res_log[$];   // delivered results, as seen on the port
  bit            grant_log[$];
  bit            model_idle = 1'b1;
  bit            model_rr   = 1'b0;
  int            acc_cyc    = 0;
  int            lat        = 0;
  int            acc0       = 0;
  int            acc1       = 0;
  int            done_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // reference result: remainder of the whole operand, divisor 0 is an error result
  function automatic logic [DW+1:0] model(input bit s, input logic [W-1:0] d, input logic [DW-1:0] dv);
    int r;
    bit z;
    if (dv == '0) begin
      r = 0;
      z = 1'b0;
    end else begin
      r = int'(d) % int'(dv);
      z = (r == 0);
    end
    return {s, z, DW'(r)};
  endfunction

  function automatic logic [W-1:0] rand_word();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  // sampled mid-cycle: check outputs against the model, then advance the model
  task automatic sample();
    bit e0, e1, ev;
    logic [DW+1:0] got;
    if (!rst_n) begin
      exp_q.delete();
      model_idle = 1'b1;
      model_rr   = 1'b0;
      return;
    end
    e0 = 1'b0;
    e1 = 1'b0;
    if (model_idle) begin
      if (req0_valid && (!req1_valid || !model_rr)) e0 = 1'b1;
      else if (req1_valid) e1 = 1'b1;
    end
    ev  = !model_idle && (cyc >= acc_cyc + lat);
    got = {res_src, res_div, res_rem};
    check("req0_ready", 32'(req0_ready), 32'(e0));
    check("req1_ready", 32'(req1_ready), 32'(e1));
    check("busy", 32'(busy), 32'(!model_idle));
    check("res_valid", 32'(res_valid), 32'(ev));
    if (ev) check("result", 32'(got), 32'(exp_q[0]));
    if (!model_idle && abort_s) begin
      void'(exp_q.pop_front());
      model_idle = 1'b1;
    end else if (ev && res_ready) begin
      void'(exp_q.pop_front());
      res_log.push_back(got);
      done_cnt++;
      model_idle = 1'b1;
    end
    if (e0 || e1) begin
      exp_q.push_back(model(e1, e1 ? req1_data : req0_data, divisor));
      model_idle = 1'b0;
      acc_cyc    = cyc + 1;
      lat        = (divisor == '0) ? 0 : W;
      model_rr   = e0;
      grant_log.push_back(e1);
      if (e1) acc1++;
      else acc0++;
    end
  endtask

  // one clock: sample at the falling edge, return just after the rising edge
  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int t;
    t = 0;
    while (!model_idle && t < budget) begin
      step();
      t++;
    end
    check(tag, 32'(model_idle), 32'd1);
  endtask

  // one directed job with explicit expected result and optional backpressure
  task automatic send(input bit s, input logic [W-1:0] d, input logic [DW-1:0] dv,
                      input int hold, input bit ed, input logic [DW-1:0] er);
    int a, t;
    a         = s ? acc1 : acc0;
    divisor   = dv;
    res_ready = 1'b0;
    if (s) begin req1_valid = 1'b1; req1_data = d; end
    else   begin req0_valid = 1'b1; req0_data = d; end
    t = 0;
    while ((s ? acc1 : acc0) == a && t < 20) begin step(); t++; end
    check("accept_seen", 32'((s ? acc1 : acc0) != a), 32'd1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    divisor    = ~dv;  // changes after the accept must not matter
    t = 0;
    while (!res_valid && t < W + 4) begin step(); t++; end
    check("latency", 32'(t), (dv == '0) ? 32'd0 : 32'(W));
    repeat (hold) begin
      if (s) req0_valid = 1'b1;
      else   req1_valid = 1'b1;
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b1;
    wait_idle(5, "result_taken");
    res_ready = 1'b0;
    check("d_src", 32'(res_log[$][DW+1]), 32'(s));
    check("d_div", 32'(res_log[$][DW]), 32'(ed));
    check("d_rem", 32'(res_log[$][DW-1:0]), 32'(er));
  endtask

  initial begin
    int t, a, dc, s0, s1;

    // reset state
    #1;
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_outputs", 32'({res_src, res_div, res_rem}), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;

    // both valid from reset: req0, req1, req0
    grant_log.delete();
    res_log.delete();
    divisor = 4'd3;
    req0_data = 16'd9;
    req1_data = 16'd10;
    res_ready = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    t = 0;
    while (grant_log.size() < 3 && t < 100) begin step(); t++; end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle(40, "rr_drain");
    check("rr_grant0", 32'(grant_log[0]), 32'd0);
    check("rr_grant1", 32'(grant_log[1]), 32'd1);
    check("rr_grant2", 32'(grant_log[2]), 32'd0);
    check("rr_res0", 32'(res_log[0]), 32'({1'b0, 1'b1, 4'd0}));
    check("rr_res1", 32'(res_log[1]), 32'({1'b1, 1'b0, 4'd1}));
    res_ready = 1'b0;

    // directed jobs
    send(1'b0, 16'd35,   4'd5, 0, 1'b1, 4'd0);
    send(1'b1, 16'hFFFF, 4'd3, 5, 1'b1, 4'd0);
    send(1'b0, 16'd100,  4'd7, 0, 1'b0, 4'd2);
    send(1'b0, 16'd20,   4'd0, 2, 1'b0, 4'd0);
    send(1'b1, 16'd20,   4'd1, 0, 1'b1, 4'd0);
    send(1'b0, 16'd0,    4'd9, 0, 1'b1, 4'd0);
    send(1'b1, 16'hFFFF, 4'd15, 1, 1'b1, 4'd0);

    // reset in the middle of a shift
    divisor = 4'd7;
    res_ready = 1'b1;
    req0_data = 16'h1234;
    req0_valid = 1'b1;
    a = acc0;
    t = 0;
    while (acc0 == a && t < 20) begin step(); t++; end
    req0_valid = 1'b0;
    repeat (8) step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_res_valid", 32'(res_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_outputs", 32'({res_src, res_div, res_rem}), 32'd0);
    step();
    rst_n = 1'b1;
    grant_log.delete();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    t = 0;
    while (grant_log.size() < 1 && t < 20) begin step(); t++; end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("post_rst_grant", 32'(grant_log[0]), 32'd0);
    wait_idle(40, "post_rst_drain");

`ifdef SERIAL_DIV_ABORT_EN
    // abort part-way through a shift
    dc = done_cnt;
    divisor = 4'd5;
    req0_data = 16'd35;
    req0_valid = 1'b1;
    a = acc0;
    t = 0;
    while (acc0 == a && t < 20) begin step(); t++; end
    req0_valid = 1'b0;
    repeat (4) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    repeat (W + 2) step();
    check("abort_no_result", 32'(done_cnt), 32'(dc));
`endif

    // randomized traffic
    s0 = acc0;
    s1 = acc1;
    repeat (1500) begin
      step();
      if (acc0 != s0) begin s0 = acc0; req0_valid = 1'b0; end
      if (acc1 != s1) begin s1 = acc1; req1_valid = 1'b0; end
      if (!req0_valid && $urandom_range(0, 3) == 0) begin
        req0_valid = 1'b1;
        req0_data  = rand_word();
      end
      if (!req1_valid && $urandom_range(0, 3) == 0) begin
        req1_valid = 1'b1;
        req1_data  = rand_word();
      end
      divisor   = DW'($urandom_range(0, 15));
      res_ready = ($urandom_range(0, 2) != 0);
`ifdef SERIAL_DIV_ABORT_EN
      abort = ($urandom_range(0, 39) == 0);
`endif
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b1;
`ifdef SERIAL_DIV_ABORT_EN
    abort = 1'b0;
`endif
    wait_idle(60, "final_drain");
    check("jobs_delivered", 32'(done_cnt > 20), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
